// File: rtl/aes_key_expand_seq_if.sv
// Key-expansion request/result bundle between a key source, the expander and the cipher cores.
// Latency: none, wiring only.
// Backpressure: none; start is a request pulse and busy/key_valid qualify the result bus.
interface aes_key_expand_seq_if #(
    parameter int NR = 10,
    parameter int NK = 4
) ();
    logic                    start;
    logic [32*NK-1:0]        key_in;
    logic                    busy;
    logic                    done;
    logic                    key_valid;
    logic [128*(NR+1)-1:0]   ExpandedKeys;

    // Requester side: issues start/key and watches the schedule.
    modport master (
        output start,
        output key_in,
        input  busy,
        input  done,
        input  key_valid,
        input  ExpandedKeys
    );

    // Expander side.
    modport slave (
        input  start,
        input  key_in,
        output busy,
        output done,
        output key_valid,
        output ExpandedKeys
    );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule: expands an NK-word cipher key into 4*(NR+1) words, one word per clock.
// Latency: start-accept edge to done-high edge is 4*(NR+1)-NK edges (40/46/52 for AES-128/192/256).
// Backpressure: none; start is ignored while busy, consumers qualify ExpandedKeys on key_valid.
module aes_key_expand_seq #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input logic                 clk,
    input logic                 reset,
    aes_key_expand_seq_if.slave bus
);
    localparam int TOTAL = 4 * (NR + 1);
    localparam int KW    = 128 * (NR + 1);
    localparam int IW    = $clog2(TOTAL);
    localparam int PW    = $clog2(NK + 1);

    localparam logic [IW-1:0] NK_W = IW'(NK);
    localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);

    // Forward AES S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic            key_valid_q;
    logic [IW-1:0]   idx_q;
    // Position of idx within its NK-word group, i.e. idx % NK without a divider.
    logic [PW-1:0]   pos_q;
    logic [7:0]      rcon_q;
    logic [31:0]     w_q [TOTAL];

    logic [IW-1:0]   prev_idx;
    logic [IW-1:0]   back_idx;
    logic [31:0]     t_word;
    logic [31:0]     sub_in;
    logic [31:0]     sub_out;
    logic [31:0]     temp;
    logic [31:0]     new_word;
    logic [KW-1:0]   ek_flat;

    // Byte substitution; the index {~b,3'b111} equals 2047-8*b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Next schedule word from w[idx-1] and w[idx-NK]; the four S-boxes are shared
    // between the RotWord group-start step and the mid-group step of AES-256.
    always_comb begin
        prev_idx = idx_q - IW'(1);
        back_idx = idx_q - NK_W;
        t_word   = w_q[prev_idx];
        sub_in   = (pos_q == '0) ? {t_word[23:0], t_word[31:24]} : t_word;
        sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                    sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        if (pos_q == '0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK > 6 && pos_q == PW'(4)) begin
            temp = sub_out;
        end else begin
            temp = t_word;
        end
        new_word = w_q[back_idx] ^ temp;
    end

    // Control FSM and word storage: load the key on an accepted start, then write one word per edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            idx_q       <= '0;
            pos_q       <= '0;
            rcon_q      <= 8'h01;
            for (int j = 0; j < TOTAL; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        for (int j = 0; j < NK; j++) begin
                            w_q[j] <= bus.key_in[32*NK-1-32*j -: 32];
                        end
                        idx_q       <= NK_W;
                        pos_q       <= '0;
                        rcon_q      <= 8'h01;
                        busy_q      <= 1'b1;
                        key_valid_q <= 1'b0;
                        state_q     <= EXPAND;
                    end
                end
                EXPAND: begin
                    w_q[idx_q] <= new_word;
                    idx_q      <= idx_q + IW'(1);
                    pos_q      <= (pos_q == PW'(NK - 1)) ? '0 : pos_q + PW'(1);
                    if (pos_q == '0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (idx_q == LAST) begin
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Flatten the word store: w[0] in the MSBs, w[TOTAL-1] in the LSBs.
    always_comb begin
        ek_flat = '0;
        for (int j = 0; j < TOTAL; j++) begin
            ek_flat[KW-1-32*j -: 32] = w_q[j];
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.ExpandedKeys = ek_flat;
endmodule
